tb_timer_periph: RTL and testbench
==================================

TB_TIMER_PERIPH -- requirements
Module: tb_timer_periph

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of the register offset bus.
REQ-002 Parameter CMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF, reset value of MTIMECMP.
REQ-003 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 Port req_i  input  1  bus request from the data-side interconnect.
REQ-006 Port addr_i  input  ADDR_WIDTH  byte offset of the register, word aligned; addr_i[1:0] ignored.
REQ-007 Port we_i  input  1  1 = write, 0 = read.
REQ-008 Port be_i  input  4  byte enables for writes.
REQ-009 Port wdata_i  input  32  write data.
REQ-010 Port gnt_o  output  1  grant.
REQ-011 Port rvalid_o  output  1  response valid.
REQ-012 Port rdata_o  output  32  read data.
REQ-013 Port irq_timer_o  output  1  level timer interrupt to the core's irq_timer_i.

Function
REQ-014 gnt_o SHALL equal req_i combinationally; every request is granted in its request cycle.
REQ-015 rvalid_o SHALL be asserted exactly one cycle after each granted request; back-to-back requests give back-to-back rvalid.
REQ-016 rdata_o SHALL carry the register value sampled in the grant cycle for reads, 0 for writes, and 0 whenever rvalid_o is 0.
REQ-017 Register map: 0x00 MTIME[31:0], 0x04 MTIME[63:32], 0x08 MTIMECMP[31:0], 0x0C MTIMECMP[63:32], 0x10 CTRL.
REQ-018 CTRL bit 0 = EN; bits [15:8] = PRESC when prescaling is compiled in; all other bits read 0, writes ignored.
REQ-019 Unmapped offsets SHALL read 0; writes to them SHALL be ignored with the normal grant/rvalid response.
REQ-020 Writes SHALL update only bytes whose be_i bit is set.
REQ-021 MTIME SHALL be a 64-bit counter incrementing by 1 on each tick while EN=1, wrapping from all-ones to 0.
REQ-022 A write to either MTIME half in a tick cycle SHALL win; the full 64-bit increment is suppressed that cycle.
REQ-023 irq_timer_o SHALL be registered: next value = EN && (MTIME >= MTIMECMP), unsigned 64-bit compare on current register values.
REQ-024 irq_timer_o SHALL be deasserted in the cycle after software raises MTIMECMP above MTIME or clears EN; there is no separate ack.
REQ-025 Clearing EN SHALL freeze MTIME; MTIME and MTIMECMP remain writable while EN=0.

Reset
REQ-026 On rst_ni=0 at a rising edge: MTIME=0, MTIMECMP=CMP_RESET, CTRL=0, prescale counter=0, rvalid_o=0, rdata_o=0, irq_timer_o=0.
REQ-027 Reset SHALL take priority over any concurrent bus access; a request outstanding at reset SHALL receive no rvalid.

Configuration
REQ-028 Macro TB_TIMER_PRESCALER_EN defined: an 8-bit prescale counter counts cycles while EN=1; a tick occurs when it equals PRESC, and it then returns to 0; PRESC=0 ticks every cycle; a write to CTRL clears the prescale counter.
REQ-029 Macro TB_TIMER_PRESCALER_EN undefined: a tick occurs every cycle while EN=1; CTRL[15:8] reads 0 and writes to it are ignored.

Verification
REQ-030 Reset, then read 0x08, 0x0C, 0x10 -> rdata 0xFFFFFFFF, 0xFFFFFFFF, 0x0; irq_timer_o=0.
REQ-031 Write MTIMECMP=10, write CTRL=1 -> irq_timer_o rises 11 cycles after the EN write takes effect (MTIME reaches 10 after 10 ticks, plus 1 registered cycle); write MTIMECMP_LO=100 -> irq falls the next cycle.
REQ-032 EN=1, write MTIME_LO=0xFFFFFFFF and MTIME_HI=0 -> MTIME_HI reads 1 after the next tick; write MTIME=all-ones -> MTIME wraps to 0.
REQ-033 Write 0x11223344 to 0x08 with be=4'b0101 after reset -> read back 0xFF22FF44.
REQ-034 With TB_TIMER_PRESCALER_EN, write CTRL=0x0301 -> MTIME advances once per 4 cycles; same write without the macro -> MTIME advances once per cycle and CTRL reads 0x1.
REQ-035 Back-to-back reads of 0x00 with EN=1 -> rvalid on consecutive cycles, values differing by 1; rst_ni low mid-burst -> no further rvalid, all registers at reset values.

Source files
------------

// File: rtl/tb_timer_periph_if.sv
// Data-side bus bundle for the machine timer: request/grant plus a one-cycle response.
// Latency: pure wiring, no storage.
// Backpressure: none; the slave grants every request in its request cycle.
`timescale 1ns/1ps
interface tb_timer_periph_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  req_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  we_i;
  logic [3:0]            be_i;
  logic [31:0]           wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [31:0]           rdata_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/tb_timer_periph.sv
// Machine timer peripheral: 64-bit MTIME/MTIMECMP, CTRL (EN, optional PRESC), level timer interrupt.
// Latency: grant in the request cycle, rvalid/rdata one cycle later; irq registered one cycle after compare.
// Backpressure: none; every request is granted immediately. Optional prescaler: `define TB_TIMER_PRESCALER_EN.
`timescale 1ns/1ps
module tb_timer_periph #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  tb_timer_periph_if.slave bus,
  output logic             irq_timer_o
);

  // Word indices of the register map (byte offset >> 2).
  localparam logic [ADDR_WIDTH-3:0] IDX_MTIME_LO = (ADDR_WIDTH-2)'(0);
  localparam logic [ADDR_WIDTH-3:0] IDX_MTIME_HI = (ADDR_WIDTH-2)'(1);
  localparam logic [ADDR_WIDTH-3:0] IDX_CMP_LO   = (ADDR_WIDTH-2)'(2);
  localparam logic [ADDR_WIDTH-3:0] IDX_CMP_HI   = (ADDR_WIDTH-2)'(3);
  localparam logic [ADDR_WIDTH-3:0] IDX_CTRL     = (ADDR_WIDTH-2)'(4);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_en;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_irq;

  logic [ADDR_WIDTH-3:0] w_word;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_wr_mtime_lo;
  logic                  w_wr_mtime_hi;
  logic                  w_wr_cmp_lo;
  logic                  w_wr_cmp_hi;
  logic                  w_wr_ctrl;
  logic                  w_tick;
  logic [31:0]           w_ctrl_val;
  logic [31:0]           w_rd_val;

  // Merge write data into an existing word, one byte lane per enable bit.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  assign w_word        = bus.addr_i[ADDR_WIDTH-1:2];
  assign w_wr          = bus.req_i & bus.we_i;
  assign w_rd          = bus.req_i & ~bus.we_i;
  assign w_wr_mtime_lo = w_wr && (w_word == IDX_MTIME_LO);
  assign w_wr_mtime_hi = w_wr && (w_word == IDX_MTIME_HI);
  assign w_wr_cmp_lo   = w_wr && (w_word == IDX_CMP_LO);
  assign w_wr_cmp_hi   = w_wr && (w_word == IDX_CMP_HI);
  assign w_wr_ctrl     = w_wr && (w_word == IDX_CTRL);

`ifdef TB_TIMER_PRESCALER_EN
  logic [7:0] r_presc;
  logic [7:0] r_presc_cnt;

  assign w_tick     = r_en && (r_presc_cnt == r_presc);
  assign w_ctrl_val = {16'h0000, r_presc, 7'b0000000, r_en};

  // Prescale counter: restarts on any CTRL write, otherwise runs while enabled and wraps at PRESC.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_presc_cnt <= 8'd0;
    end else if (w_wr_ctrl) begin
      r_presc_cnt <= 8'd0;
    end else if (r_en) begin
      r_presc_cnt <= (r_presc_cnt == r_presc) ? 8'd0 : r_presc_cnt + 8'd1;
    end
  end

  // CTRL register: EN in lane 0, PRESC in lane 1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_en    <= 1'b0;
      r_presc <= 8'd0;
    end else if (w_wr_ctrl) begin
      if (bus.be_i[0]) r_en    <= bus.wdata_i[0];
      if (bus.be_i[1]) r_presc <= bus.wdata_i[15:8];
    end
  end
`else
  assign w_tick     = r_en;
  assign w_ctrl_val = {31'h0, r_en};

  // CTRL register: only EN exists without the prescaler.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_en <= 1'b0;
    end else if (w_wr_ctrl && bus.be_i[0]) begin
      r_en <= bus.wdata_i[0];
    end
  end
`endif

  // Read mux over the register map; holes read as zero.
  always_comb begin
    w_rd_val = 32'h0;
    case (w_word)
      IDX_MTIME_LO: w_rd_val = r_mtime[31:0];
      IDX_MTIME_HI: w_rd_val = r_mtime[63:32];
      IDX_CMP_LO:   w_rd_val = r_mtimecmp[31:0];
      IDX_CMP_HI:   w_rd_val = r_mtimecmp[63:32];
      IDX_CTRL:     w_rd_val = w_ctrl_val;
      default:      w_rd_val = 32'h0;
    endcase
  end

  // Response stage: one rvalid per granted request, data only for reads.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_rvalid <= bus.req_i;
      r_rdata  <= w_rd ? w_rd_val : 32'h0;
    end
  end

  // MTIME counter: a software write to either half beats the tick for the whole 64 bits.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mtime <= 64'h0;
    end else if (w_wr_mtime_lo) begin
      r_mtime[31:0] <= apply_be(r_mtime[31:0], bus.wdata_i, bus.be_i);
    end else if (w_wr_mtime_hi) begin
      r_mtime[63:32] <= apply_be(r_mtime[63:32], bus.wdata_i, bus.be_i);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // MTIMECMP: plain byte-writable storage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mtimecmp <= CMP_RESET;
    end else if (w_wr_cmp_lo) begin
      r_mtimecmp[31:0] <= apply_be(r_mtimecmp[31:0], bus.wdata_i, bus.be_i);
    end else if (w_wr_cmp_hi) begin
      r_mtimecmp[63:32] <= apply_be(r_mtimecmp[63:32], bus.wdata_i, bus.be_i);
    end
  end

  // Level interrupt from current register values; software clears it by moving MTIMECMP or dropping EN.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_en && (r_mtime >= r_mtimecmp);
    end
  end

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = r_rdata;
  assign irq_timer_o  = r_irq;

endmodule

// File: tb/tb_tb_timer_periph.sv
// Self-checking bench for the machine timer: register table plus timing sequences.
// Latency: inputs driven and outputs sampled on the falling edge, one bus op per clock.
// Backpressure: none expected; grant is checked on every access.
`timescale 1ns/1ps
module tb_tb_timer_periph;
  localparam int AW = 8;

`ifdef TB_TIMER_PRESCALER_EN
  localparam logic [31:0] CTRL_FF00 = 32'h0000_FF00;
  localparam logic [31:0] CTRL_0301 = 32'h0000_0301;
  localparam int          TICK_DIV  = 4;
`else
  localparam logic [31:0] CTRL_FF00 = 32'h0000_0000;
  localparam logic [31:0] CTRL_0301 = 32'h0000_0001;
  localparam int          TICK_DIV  = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  tb_timer_periph_if #(.ADDR_WIDTH(AW)) bus_if ();

  tb_timer_periph #(
    .ADDR_WIDTH(AW),
    .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus_if.slave),
    .irq_timer_o(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.req_i   = 1'b0;
    bus_if.we_i    = 1'b0;
    bus_if.addr_i  = '0;
    bus_if.be_i    = 4'h0;
    bus_if.wdata_i = 32'h0;
  endtask

  // Called at a falling edge; returns at the next falling edge with the response.
  task automatic bus_op(input logic we, input logic [7:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd);
    bus_if.req_i   = 1'b1;
    bus_if.we_i    = we;
    bus_if.addr_i  = addr;
    bus_if.be_i    = be;
    bus_if.wdata_i = wd;
    #1;
    check("gnt", 32'(bus_if.gnt_o), 32'd1);
    @(negedge clk);
    check("rvalid", 32'(bus_if.rvalid_o), 32'd1);
    rd = bus_if.rdata_o;
    bus_idle();
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] rd;
    bus_op(1'b1, addr, be, wd, rd);
    check("wr_rdata", rd, 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_op(1'b0, addr, 4'h0, 32'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] first;
    int          cnt;

    vecs[0]  = '{1'b0, 8'h08, 4'h0, 32'h0,         32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, 8'h0C, 4'h0, 32'h0,         32'hFFFF_FFFF};
    vecs[2]  = '{1'b0, 8'h10, 4'h0, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 8'h00, 4'h0, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 8'h04, 4'h0, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, 8'h08, 4'h5, 32'h1122_3344, 32'h0};
    vecs[6]  = '{1'b0, 8'h08, 4'h0, 32'h0,         32'hFF22_FF44};
    vecs[7]  = '{1'b0, 8'h0A, 4'h0, 32'h0,         32'hFF22_FF44};
    vecs[8]  = '{1'b1, 8'h0C, 4'hF, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 8'h0C, 4'h0, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 8'h14, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[11] = '{1'b0, 8'h14, 4'h0, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 8'hFC, 4'h0, 32'h0,         32'h0};
    vecs[13] = '{1'b1, 8'h10, 4'hF, 32'hFFFF_FF00, 32'h0};
    vecs[14] = '{1'b0, 8'h10, 4'h0, 32'h0,         CTRL_FF00};
    vecs[15] = '{1'b1, 8'h00, 4'hC, 32'h1234_5678, 32'h0};
    vecs[16] = '{1'b0, 8'h00, 4'h0, 32'h0,         32'h1234_0000};
    vecs[17] = '{1'b1, 8'h04, 4'h3, 32'hAABB_CCDD, 32'h0};
    vecs[18] = '{1'b0, 8'h04, 4'h0, 32'h0,         32'h0000_CCDD};
    vecs[19] = '{1'b1, 8'h10, 4'hF, 32'h0,         32'h0};
    vecs[20] = '{1'b0, 8'h10, 4'h0, 32'h0,         32'h0};

    bus_idle();
    @(negedge clk);
    do_reset();

    // Reset state of the response path and interrupt.
    check("rst_rvalid", 32'(bus_if.rvalid_o), 32'd0);
    check("rst_rdata",  bus_if.rdata_o,       32'h0);
    check("rst_irq",    32'(irq),             32'd0);
    check("idle_gnt",   32'(bus_if.gnt_o),    32'd0);

    // Register table, EN=0 throughout so values are timing independent.
    for (int i = 0; i < 21; i++) begin
      bus_op(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    // MTIME now exceeds MTIMECMP but EN=0 keeps the interrupt low.
    check("irq_gated_by_en", 32'(irq), 32'd0);
    @(negedge clk);
    check("idle_rvalid", 32'(bus_if.rvalid_o), 32'd0);
    check("idle_rdata",  bus_if.rdata_o,       32'h0);

    // Interrupt rise timing and software deassertion.
    do_reset();
    wr(8'h08, 32'd10, 4'hF);
    wr(8'h0C, 32'd0,  4'hF);
    check("irq_before_en", 32'(irq), 32'd0);
    wr(8'h10, 32'd1, 4'hF);
    cnt = 0;
    while (!irq && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("irq_rise_cycles", 32'(cnt), 32'd11);
    wr(8'h08, 32'd100, 4'hF);
    check("irq_still_high", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_fall_cmp", 32'(irq), 32'd0);
    wr(8'h08, 32'd0, 4'hF);
    @(negedge clk);
    check("irq_rearm", 32'(irq), 32'd1);
    wr(8'h10, 32'd0, 4'hF);
    @(negedge clk);
    check("irq_fall_en", 32'(irq), 32'd0);
    bus_op(1'b0, 8'h00, 4'h0, 32'h0, first);
    rd_chk("mtime_frozen", 8'h00, first);
    wr(8'h00, 32'd5, 4'hF);
    rd_chk("mtime_wr_disabled", 8'h00, 32'd5);

    // Carry into the high half, then full 64-bit wrap, with EN=1.
    do_reset();
    wr(8'h10, 32'd1, 4'hF);
    wr(8'h00, 32'hFFFF_FFFF, 4'hF);
    wr(8'h04, 32'h0, 4'hF);
    @(negedge clk);
    rd_chk("carry_hi", 8'h04, 32'd1);
    rd_chk("carry_lo", 8'h00, 32'd1);
    wr(8'h00, 32'hFFFF_FFFF, 4'hF);
    wr(8'h04, 32'hFFFF_FFFF, 4'hF);
    rd_chk("wrap_pre",   8'h00, 32'hFFFF_FFFF);
    rd_chk("wrap_lo",    8'h00, 32'h0);
    rd_chk("wrap_hi",    8'h04, 32'h0);

    // Back-to-back reads: consecutive rvalid, values one apart.
    for (int i = 0; i < 4; i++) begin
      rd_chk($sformatf("b2b%0d", i), 8'h00, 32'd2 + 32'(i));
    end
    // Reset asserted together with a pending request: no response may follow.
    bus_if.req_i  = 1'b1;
    bus_if.we_i   = 1'b0;
    bus_if.addr_i = 8'h00;
    rst_n         = 1'b0;
    @(negedge clk);
    check("rst_mid_rvalid", 32'(bus_if.rvalid_o), 32'd0);
    check("rst_mid_rdata",  bus_if.rdata_o,       32'h0);
    check("rst_mid_irq",    32'(irq),             32'd0);
    bus_idle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rvalid", 32'(bus_if.rvalid_o), 32'd0);
    rd_chk("post_rst_cmp_lo", 8'h08, 32'hFFFF_FFFF);
    rd_chk("post_rst_cmp_hi", 8'h0C, 32'hFFFF_FFFF);
    rd_chk("post_rst_ctrl",   8'h10, 32'h0);
    rd_chk("post_rst_mt_lo",  8'h00, 32'h0);
    rd_chk("post_rst_mt_hi",  8'h04, 32'h0);

    // Prescaler: PRESC=3 ticks every 4th cycle when compiled in, else every cycle.
    do_reset();
    wr(8'h10, 32'h0000_0301, 4'hF);
    rd_chk("presc_ctrl", 8'h10, CTRL_0301);
    for (int k = 2; k <= 9; k++) begin
      rd_chk($sformatf("presc_mtime%0d", k), 8'h00, 32'((k - 1) / TICK_DIV));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
